// File: rtl/param_signed_seq_alu.sv
// WIDTH-bit signed ALU with valid/ready handshakes: add/sub finish in one cycle,
// mul/div iterate WIDTH cycles on operand magnitudes and fix the sign at the end.
module param_signed_seq_alu #(
  parameter int WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] s,
  output logic signed [WIDTH-1:0] r,
  output logic                    ovf,
  output logic                    zero,
  output logic                    neg,
  output logic                    dz
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  function automatic logic add_ovf(input logic [WIDTH-1:0] x, y, sum);
    return (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] x, y, diff);
    return (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Most-negative maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic mul_ovf(input logic [2*WIDTH-1:0] p);
    return !((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]));
  endfunction

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic               div_q, div_d;
  logic               nres_q, nres_d;
  logic               nega_q, nega_d;
  logic signed [WIDTH-1:0] s_q, s_d, r_q, r_d;
  logic               ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d, dz_q, dz_d;
  logic               ld;

  // Multiply step: work = {accumulator, multiplier}, shift right each cycle.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  assign mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, mag_q} : '0);
  assign mul_nxt = {mul_sum, work_q[WIDTH-1:1]};

  // Restoring divide step: work = {remainder, dividend/quotient}; remainder < divisor.
  logic [WIDTH-1:0]   rem_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_nxt;
  assign rem_sh   = {work_q[2*WIDTH-2:WIDTH], work_q[WIDTH-1]};
  assign div_diff = {1'b0, rem_sh} - {1'b0, mag_q};
  assign div_ge   = ~div_diff[WIDTH];
  assign div_nxt  = {(div_ge ? div_diff[WIDTH-1:0] : rem_sh), work_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   q_mag, rem_mag, fin_s, fin_r;
  logic               fin_ovf;
  assign prod    = nres_q ? (~mul_nxt + 1'b1) : mul_nxt;
  assign q_mag   = div_nxt[WIDTH-1:0];
  assign rem_mag = div_nxt[2*WIDTH-1:WIDTH];
  assign fin_s   = div_q ? (nres_q ? (~q_mag + 1'b1) : q_mag) : prod[WIDTH-1:0];
  assign fin_r   = div_q ? (nega_q ? (~rem_mag + 1'b1) : rem_mag) : '0;
  assign fin_ovf = div_q ? (!nres_q && q_mag[WIDTH-1]) : mul_ovf(prod);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    mag_d   = mag_q;
    div_d   = div_q;
    nres_d  = nres_q;
    nega_d  = nega_q;
    s_d     = s_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    ld      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          nres_d = a[WIDTH-1] ^ b[WIDTH-1];
          nega_d = a[WIDTH-1];
          cnt_d  = '0;
          if (op == OP_ADD) begin
            s_d = a + b;  r_d = '0;  ovf_d = add_ovf(a, b, s_d);  dz_d = 1'b0;
            ld = 1'b1;  state_d = S_DONE;
          end else if (op == OP_SUB) begin
            s_d = a - b;  r_d = '0;  ovf_d = sub_ovf(a, b, s_d);  dz_d = 1'b0;
            ld = 1'b1;  state_d = S_DONE;
          end else if (op == OP_MUL) begin
            mag_d = magnitude(a);  work_d = {{WIDTH{1'b0}}, magnitude(b)};
            div_d = 1'b0;  state_d = S_CALC;
          end else if (b == '0) begin
            s_d = '0;  r_d = a;  ovf_d = 1'b0;  dz_d = 1'b1;
            ld = 1'b1;  state_d = S_DONE;
          end else begin
            mag_d = magnitude(b);  work_d = {{WIDTH{1'b0}}, magnitude(a)};
            div_d = 1'b1;  state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        work_d = div_q ? div_nxt : mul_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          s_d = fin_s;  r_d = fin_r;  ovf_d = fin_ovf;  dz_d = 1'b0;
          ld = 1'b1;  state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (ld) begin
      zero_d = (s_d == '0);
      neg_d  = s_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
    end
  end

  // Iteration datapath carries no reset; it is always reloaded on acceptance.
  always_ff @(posedge clk) begin
    work_q <= work_d;
    mag_q  <= mag_d;
    div_q  <= div_d;
    nres_q <= nres_d;
    nega_q <= nega_d;
  end

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign s    = s_q;
  assign r    = r_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign neg  = neg_q;
  assign dz   = dz_q;

endmodule

// File: doc/param_signed_seq_alu.md
Name: param_signed_seq_alu

Overview:
- Parametrised, multi-cycle successor to the 6-bit signed ALU.
- Performs WIDTH-bit two's-complement add, subtract, multiply and divide.
- Uses a valid/ready handshake on both input and output.
- Add/sub complete in one cycle; multiply/divide are iterative over WIDTH cycles.
- Reports status flags and a remainder, and sits between the datapath controller and the register file.

Parameters:
- WIDTH, 6, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  input  1  operand set on a/b/op is valid.
- in_ready  output  1  block can accept an operation (high only in IDLE).
- op  input  2  0=add, 1=sub (a-b), 2=mul, 3=div (a/b).
- a  input  WIDTH  signed operand A (MSB = sign).
- b  input  WIDTH  signed operand B (MSB = sign).
- out_valid  output  1  result/flags valid, held until out_ready.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  signed result (sum/difference/low product/quotient).
- r  output  WIDTH  signed remainder for div; 0 for other ops.
- ovf  output  1  signed overflow.
- zero  output  1  s == 0.
- neg  output  1  s[WIDTH-1].
- dz  output  1  divide by zero (div only).

Behaviour:
- Reset: while rst_n is low at a rising edge, state goes to IDLE. Reset values: s=0, r=0, ovf=0, zero=0, neg=0, dz=0, out_valid=0. in_ready is forced 0 while rst_n is low.
- Reset in CALC or DONE aborts the operation; no out_valid is produced for it.
- States:
  - IDLE: in_ready=1. Accepting edge = rising edge with in_valid && in_ready. a, b and op are captured there; later input changes are ignored.
  - IDLE -> DONE on acceptance for op 0/1, and for op 3 with b==0.
  - IDLE -> CALC on acceptance for op 2, and for op 3 with b!=0.
  - CALC: iteration counter runs WIDTH cycles. After WIDTH rising edges in CALC, state goes to DONE. in_ready=0.
  - DONE: out_valid=1. s, r and flags are stable and held while out_ready=0. On a rising edge with out_ready=1, state goes to IDLE and out_valid drops.
  - No acceptance occurs in the same cycle as result retirement.
- Latency, counted from the accepting edge to the first cycle with out_valid=1:
  - 1 cycle for add, sub and div-by-zero.
  - WIDTH+1 cycles for mul and div.
  - Max throughput is one op per 2 cycles for add/sub.
- Add: s = (a+b) mod 2^WIDTH. ovf = 1 when a and b have the same sign and s has a different sign.
- Sub: s = (a-b) mod 2^WIDTH. ovf = 1 when a and b have different signs and the sign of s differs from the sign of a.
- Mul: the full 2*WIDTH signed product is formed; s = low WIDTH bits. ovf = 1 when the product is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]. The algorithm (shift-add on magnitudes, then sign fix, or Booth) is free, but it must iterate WIDTH cycles.
- Div: quotient truncates toward zero; remainder takes the sign of a, with a = s*b + r.
  - Special case a = most-negative, b = -1: s = most-negative, r = 0, ovf = 1.
  - Special case b = 0: dz = 1, s = 0, r = a, ovf = 0.
- Flags: zero and neg derive from the final s. dz = 0 for ops 0-2. r = 0 for ops 0-2.

Test Plan (WIDTH=6):
1. op=0, a=5, b=6 -> s=11, ovf=0, zero=0, neg=0; out_valid 1 cycle after acceptance. Then op=1, a=5, b=6 -> s=-1 (6'b111111), neg=1.
2. op=0, a=31, b=1 -> s=6'b100000 (-32), ovf=1, neg=1. Then op=1, a=-32, b=1 -> s=31, ovf=1.
3. op=2, a=-3, b=7 -> s=-21 (6'b101011), ovf=0, out_valid exactly 7 cycles after acceptance. Then op=2, a=8, b=8 -> s=0, ovf=1, zero=1.
4. op=3, a=-13, b=4 -> s=-3, r=-1, ovf=0 after 7 cycles. Then op=3, a=-32, b=-1 -> s=-32, ovf=1. Then op=3, a=9, b=0 -> dz=1, s=0, r=9, zero=1, 1-cycle latency.
5. op=0 result with out_ready held 0 for 5 cycles and in_valid toggling with new a/b -> out_valid, s and flags stay constant; in_ready=0 throughout; the new op is accepted only after retirement.
6. rst_n driven low for 1 cycle at the 3rd CALC cycle of op=2 -> out_valid never asserts for that op; all outputs 0; in_ready=1 on the cycle after rst_n returns high; the next op=0, a=1, b=1 gives s=2.
